// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, FSM state encoding and the divider sanitising helper.
package mmio_uart_tx_pkg;

    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_CLKDIV = 2'd2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // A divider of zero would never produce a bit boundary, so it is promoted to 1.
    function automatic logic [15:0] clkdiv_sanitize(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'd0) begin
            result = 16'd1;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Small synchronous FIFO with a combinational head output; a push into a full
// FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [3:0]       count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [3:0]       count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        logic [AW-1:0] result;
        if (ptr == AW'(DEPTH - 1)) begin
            result = '0;
        end else begin
            result = ptr + AW'(1);
        end
        return result;
    endfunction

    assign empty     = (count_r == 4'd0);
    assign full      = (count_r == 4'(DEPTH));
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);

    // Storage array write port.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= 4'd0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 4'd1;
                2'b01:   count_r <= count_r - 4'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core's data bus: register decode,
// combinational read-back, TX FIFO and the frame serialiser FSM.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd_data,
    output logic        hit,
    output logic        uart_tx,
    output logic        tx_busy
);

    logic [1:0]  offset_s;
    logic        hit_s;
    logic        wr_en_s;
    logic        wr_txdata_s;
    logic        wr_status_s;
    logic        wr_clkdiv_s;
    logic        overflow_set_s;
    logic        overflow_clr_s;
    logic [31:0] status_s;
    logic        unused_ok_s;

    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic [3:0]  fifo_count_s;
    logic [7:0]  fifo_dout_s;
    logic        pop_s;

    logic [15:0] clkdiv_r;
    logic        overflow_r;

    uart_state_e state_r;
    uart_state_e state_next_s;
    logic [15:0] baud_cnt_r;
    logic [15:0] baud_next_s;
    logic [15:0] div_shadow_r;
    logic [15:0] div_next_s;
    logic [2:0]  bit_cnt_r;
    logic [2:0]  bit_next_s;
    logic [7:0]  shift_r;
    logic [7:0]  shift_next_s;
    logic        uart_tx_r;
    logic        tx_next_s;
    logic        baud_end_s;

    assign hit_s       = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset_s    = addr[3:2];
    assign wr_en_s     = we & hit_s;
    assign wr_txdata_s = wr_en_s & (offset_s == UART_TXDATA);
    assign wr_status_s = wr_en_s & (offset_s == UART_STATUS);
    assign wr_clkdiv_s = wr_en_s & (offset_s == UART_CLKDIV);
    assign unused_ok_s = &{1'b0, addr[1:0], wd[31:16]};

    // A dropped push only happens when full with no pop draining a slot this cycle.
    assign overflow_set_s = wr_txdata_s & fifo_full_s & ~pop_s;
    assign overflow_clr_s = wr_status_s & wd[STAT_OVF];

    assign hit     = hit_s;
    assign uart_tx = uart_tx_r;
    assign tx_busy = (state_r != ST_IDLE);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (wr_txdata_s),
        .pop   (pop_s),
        .din   (wd[7:0]),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Software-visible configuration and sticky overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            clkdiv_r   <= clkdiv_sanitize(DIV_RESET);
            overflow_r <= 1'b0;
        end else begin
            if (wr_clkdiv_s) begin
                clkdiv_r <= clkdiv_sanitize(wd[15:0]);
            end
            if (overflow_set_s) begin
                overflow_r <= 1'b1;
            end else if (overflow_clr_s) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // STATUS word assembly.
    always_comb begin
        status_s                       = 32'd0;
        status_s[STAT_BUSY]            = tx_busy;
        status_s[STAT_FULL]            = fifo_full_s;
        status_s[STAT_EMPTY]           = fifo_empty_s;
        status_s[STAT_OVF]             = overflow_r;
        status_s[STAT_CNT_LSB +: 4]    = fifo_count_s;
    end

    // Zero-latency read mux matching the single-cycle core's dmem timing.
    always_comb begin
        rd_data = 32'd0;
        if (hit_s) begin
            case (offset_s)
                UART_STATUS: rd_data = status_s;
                UART_CLKDIV: rd_data = {16'd0, clkdiv_r};
                default:     rd_data = 32'd0;
            endcase
        end else begin
            rd_data = 32'd0;
        end
    end

    assign baud_end_s = (baud_cnt_r == (div_shadow_r - 16'd1));

    // Serialiser next-state logic; a frame start latches the divider so later
    // CLKDIV writes only affect subsequent frames.
    always_comb begin
        state_next_s = state_r;
        baud_next_s  = baud_cnt_r;
        div_next_s   = div_shadow_r;
        bit_next_s   = bit_cnt_r;
        shift_next_s = shift_r;
        tx_next_s    = uart_tx_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                tx_next_s = 1'b1;
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    shift_next_s = fifo_dout_s;
                    div_next_s   = clkdiv_r;
                    baud_next_s  = 16'd0;
                    tx_next_s    = 1'b0;
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    baud_next_s  = 16'd0;
                    bit_next_s   = 3'd0;
                    tx_next_s    = shift_r[0];
                    state_next_s = ST_DATA;
                end else begin
                    baud_next_s = baud_cnt_r + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    baud_next_s = 16'd0;
                    if (bit_cnt_r == 3'd7) begin
                        tx_next_s    = 1'b1;
                        state_next_s = ST_STOP;
                    end else begin
                        bit_next_s   = bit_cnt_r + 3'd1;
                        shift_next_s = {1'b0, shift_r[7:1]};
                        tx_next_s    = shift_r[1];
                    end
                end else begin
                    baud_next_s = baud_cnt_r + 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_end_s) begin
                    baud_next_s = 16'd0;
                    if (!fifo_empty_s) begin
                        pop_s        = 1'b1;
                        shift_next_s = fifo_dout_s;
                        div_next_s   = clkdiv_r;
                        tx_next_s    = 1'b0;
                        state_next_s = ST_START;
                    end else begin
                        tx_next_s    = 1'b1;
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    baud_next_s = baud_cnt_r + 16'd1;
                end
            end
            default: begin
                tx_next_s    = 1'b1;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Serialiser state and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            baud_cnt_r   <= 16'd0;
            div_shadow_r <= clkdiv_sanitize(DIV_RESET);
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'd0;
            uart_tx_r    <= 1'b1;
        end else begin
            state_r      <= state_next_s;
            baud_cnt_r   <= baud_next_s;
            div_shadow_r <= div_next_s;
            bit_cnt_r    <= bit_next_s;
            shift_r      <= shift_next_s;
            uart_tx_r    <= tx_next_s;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a frame monitor pops expected bytes from a
// scoreboard queue and checks every serial cycle; bus reads check the registers.
module tb_mmio_uart_tx;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        we    = 1'b0;
    logic [31:0] addr  = 32'd0;
    logic [31:0] wd    = 32'd0;
    logic [31:0] rd_data;
    logic        hit;
    logic        uart_tx;
    logic        tx_busy;

    int          n_checks    = 0;
    int          n_errors    = 0;
    int          cyc         = 0;
    int          last_wr_cyc = 0;
    int          frames_done = 0;
    logic [7:0]  exp_q[$];
    int          start_q[$];
    logic [15:0] model_div   = 16'd868;

    logic        mon_active  = 1'b0;
    int          mon_cyc     = 0;
    int          mon_div     = 1;
    logic [7:0]  mon_data    = 8'd0;

    always #5 clock = ~clock;

    mmio_uart_tx #(
        .BASE_ADDR  (32'h0000_0400),
        .FIFO_DEPTH (8),
        .DIV_RESET  (16'd868)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .we      (we),
        .addr    (addr),
        .wd      (wd),
        .rd_data (rd_data),
        .hit     (hit),
        .uart_tx (uart_tx),
        .tx_busy (tx_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        we   = 1'b1;
        addr = a;
        wd   = d;
        @(posedge clock);
        #1;
        last_wr_cyc = cyc;
        we = 1'b0;
        if (a == 32'h0000_0408) begin
            model_div = (d[15:0] == 16'd0) ? 16'd1 : d[15:0];
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accepted);
        bus_write(32'h0000_0400, {24'd0, b});
        if (accepted) exp_q.push_back(b);
    endtask

    task automatic read_check(input string tag, input logic [31:0] a,
                              input logic [31:0] exp_rd, input logic exp_hit);
        @(negedge clock);
        we   = 1'b0;
        addr = a;
        #1;
        check_eq({tag, "_rd"}, rd_data, exp_rd);
        check_eq({tag, "_hit"}, 32'(hit), 32'(exp_hit));
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int n = 0;
        while ((exp_q.size() != 0 || mon_active || tx_busy) && n < max_cycles) begin
            @(negedge clock);
            n++;
        end
        check_eq({tag, "_idle_in_time"}, 32'(n < max_cycles), 32'd1);
    endtask

    // Cycle counter: value after edge k is k.
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Frame monitor: every cycle of every frame is checked against the scoreboard byte.
    initial forever begin
        int   idx;
        logic exp_bit;
        @(negedge clock);
        if (reset) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && uart_tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_start", 32'(uart_tx), 32'd1);
                end else begin
                    mon_data   = exp_q.pop_front();
                    mon_div    = int'(model_div);
                    mon_cyc    = 0;
                    mon_active = 1'b1;
                    start_q.push_back(cyc);
                end
            end
            if (mon_active) begin
                idx = mon_cyc / mon_div;
                if (idx == 0) exp_bit = 1'b0;
                else if (idx == 9) exp_bit = 1'b1;
                else exp_bit = mon_data[idx-1];
                check_eq("frame_bit", 32'(uart_tx), 32'(exp_bit));
                check_eq("busy_in_frame", 32'(tx_busy), 32'd1);
                mon_cyc++;
                if (mon_cyc == 10 * mon_div) begin
                    mon_active = 1'b0;
                    frames_done++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n1;
        int fd;

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Reset state and address decode.
        read_check("t1_status", 32'h0000_0404, 32'h0000_0004, 1'b1);
        check_eq("t1_uart_tx", 32'(uart_tx), 32'd1);
        check_eq("t1_tx_busy", 32'(tx_busy), 32'd0);
        read_check("t1_miss", 32'h0000_03FC, 32'd0, 1'b0);
        read_check("t1_clkdiv", 32'h0000_0408, 32'd868, 1'b1);
        read_check("t1_reserved", 32'h0000_040C, 32'd0, 1'b1);
        read_check("t1_txdata", 32'h0000_0400, 32'd0, 1'b1);
        bus_write(32'h0000_0408, 32'd0);
        read_check("t1_clkdiv_zero", 32'h0000_0408, 32'd1, 1'b1);

        // Single frame, divider 4: exact start latency and busy fall edge.
        bus_write(32'h0000_0408, 32'd4);
        start_q.delete();
        push_byte(8'hA5, 1'b1);
        n1 = last_wr_cyc;
        repeat (40) @(posedge clock);
        @(negedge clock);
        check_eq("t2_busy_last", 32'(tx_busy), 32'd1);
        @(posedge clock);
        @(negedge clock);
        check_eq("t2_busy_fall", 32'(tx_busy), 32'd0);
        check_eq("t2_nstarts", 32'(start_q.size()), 32'd1);
        check_eq("t2_start_cyc", 32'(start_q[0]), 32'(n1 + 1));
        check_eq("t2_frames", 32'(frames_done), 32'd1);
        read_check("t2_status", 32'h0000_0404, 32'h0000_0004, 1'b1);

        // Back-to-back frames, divider 2.
        bus_write(32'h0000_0408, 32'd2);
        start_q.delete();
        fd = frames_done;
        push_byte(8'h3C, 1'b1);
        n1 = last_wr_cyc;
        push_byte(8'hC3, 1'b1);
        wait_idle("t3", 200);
        check_eq("t3_nstarts", 32'(start_q.size()), 32'd2);
        check_eq("t3_start0", 32'(start_q[0]), 32'(n1 + 1));
        check_eq("t3_no_gap", 32'(start_q[1]), 32'(n1 + 21));
        check_eq("t3_frames", 32'(frames_done - fd), 32'd2);

        // Overflow: ten writes, the tenth dropped.
        bus_write(32'h0000_0408, 32'd8);
        fd = frames_done;
        for (int i = 0; i < 10; i++) begin
            push_byte(8'h10 + 8'(i * 7), i < 9);
        end
        read_check("t4_status_ovf", 32'h0000_0404, 32'h0000_008B, 1'b1);
        bus_write(32'h0000_0404, 32'h0000_0008);
        read_check("t4_status_w1c", 32'h0000_0404, 32'h0000_0083, 1'b1);
        wait_idle("t4", 1500);
        check_eq("t4_frames", 32'(frames_done - fd), 32'd9);
        read_check("t4_status_end", 32'h0000_0404, 32'h0000_0004, 1'b1);

        // Divider change mid-frame applies only to the next frame.
        bus_write(32'h0000_0408, 32'd6);
        start_q.delete();
        push_byte(8'h5A, 1'b1);
        push_byte(8'h96, 1'b1);
        repeat (15) @(posedge clock);
        bus_write(32'h0000_0408, 32'd3);
        wait_idle("t5", 300);
        check_eq("t5_nstarts", 32'(start_q.size()), 32'd2);
        check_eq("t5_frame1_len", 32'(start_q[1] - start_q[0]), 32'd60);
        read_check("t5_clkdiv", 32'h0000_0408, 32'd3, 1'b1);

        // Reset during a data bit with three bytes queued.
        bus_write(32'h0000_0408, 32'd4);
        fd = frames_done;
        for (int i = 0; i < 4; i++) begin
            push_byte(8'hE1 + 8'(i), 1'b1);
        end
        repeat (5) @(posedge clock);
        @(negedge clock);
        check_eq("t6_busy_before", 32'(tx_busy), 32'd1);
        read_check("t6_count_before", 32'h0000_0404, 32'h0000_0031, 1'b1);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clock);
        @(negedge clock);
        addr = 32'h0000_0404;
        #1;
        check_eq("t6_uart_tx", 32'(uart_tx), 32'd1);
        check_eq("t6_busy", 32'(tx_busy), 32'd0);
        check_eq("t6_status", rd_data, 32'h0000_0004);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (100) @(posedge clock);
        @(negedge clock);
        check_eq("t6_no_frames", 32'(frames_done - fd), 32'd0);
        check_eq("t6_idle_tx", 32'(uart_tx), 32'd1);
        read_check("t6_status_end", 32'h0000_0404, 32'h0000_0004, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
